// File: rtl/key_entry_display.sv
// Keypad entry buffer: turns debounced one-hot key presses into hex digits, backspace and clear,
// and scans the 6-digit buffer onto a multiplexed display (active-low digit select).
`timescale 1ns/1ps
module key_entry_display #(
    parameter int DIV_CNT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_deb,
    output logic [5:0]  seg_sel,
    output logic [3:0]  data_disp,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic [2:0]  entry_count
);
    localparam int DIV_W = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CNT - 1);

    typedef enum logic {IDLE, HELD} state_t;

    state_t           state_reg;
    logic [3:0]       digits_reg [6];
    logic [3:0]       digits_next [6];
    logic [2:0]       count_reg;
    logic [2:0]       count_next;
    logic [DIV_W-1:0] div_reg;
    logic [2:0]       idx_reg;

    logic       key_any;
    logic       key_one;
    logic [3:0] key_idx;
    logic       accept;

    // A vector with exactly one bit set has no bits left after clearing its lowest set bit.
    always_comb begin
        key_any = |key_deb;
        key_one = key_any && ((key_deb & (key_deb - 16'd1)) == 16'd0);
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (key_deb[i]) key_idx = 4'(i);
        end
        accept = (state_reg == IDLE) && key_one;
    end

    always_comb begin
        for (int i = 0; i < 6; i++) digits_next[i] = digits_reg[i];
        count_next = count_reg;
        if (accept) begin
            if (key_idx <= 4'd13) begin
                for (int i = 5; i > 0; i--) digits_next[i] = digits_reg[i-1];
                digits_next[0] = key_idx;
                if (count_reg != 3'd6) count_next = count_reg + 3'd1;
            end else if (key_idx == 4'd14) begin
                if (count_reg != 3'd0) begin
                    for (int i = 0; i < 5; i++) digits_next[i] = digits_reg[i+1];
                    digits_next[5] = 4'd0;
                    count_next = count_reg - 3'd1;
                end
            end else begin
                for (int i = 0; i < 6; i++) digits_next[i] = 4'd0;
                count_next = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            for (int i = 0; i < 6; i++) digits_reg[i] <= 4'd0;
            count_reg <= 3'd0;
            div_reg   <= '0;
            idx_reg   <= 3'd0;
            seg_sel   <= 6'b111110;
            data_disp <= 4'd0;
            key_event <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            // Chords also move to HELD so nothing is accepted until all keys are released.
            case (state_reg)
                IDLE:    if (key_any)  state_reg <= HELD;
                HELD:    if (!key_any) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            key_event <= accept;
            if (accept) key_code <= key_idx;

            for (int i = 0; i < 6; i++) digits_reg[i] <= digits_next[i];
            count_reg <= count_next;

            if (div_reg == DIV_LAST) begin
                div_reg <= '0;
                idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end

            // Slot 0 stays lit even when empty so the display shows a single 0.
            data_disp <= digits_reg[idx_reg];
            if ((idx_reg < count_reg) || (idx_reg == 3'd0))
                seg_sel <= ~(6'b000001 << idx_reg);
            else
                seg_sel <= 6'b111111;
        end
    end

    assign entry_count = count_reg;

endmodule
